alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's 16-bit combinational ALU. It adds an extended opcode set, status flags, an iterative multiplier and ready/valid flow control on both sides. It sits between the decode stage (producer of operands/op) and writeback (consumer of result/flags), and can be stalled from either side.

## Interface
- WIDTH, 16, operand/result width in bits (≥4, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block will accept on this edge
- input_a  in  WIDTH  operand A
- input_b  in  WIDTH  operand B (shift amount = input_b[SHW-1:0])
- op  in  4  operation code
- out_valid  out  1  out/flags hold a completed result
- out_ready  in  1  consumer takes result on this edge
- out  out  WIDTH  result
- flag_z, flag_n, flag_c, flag_v  out  1 each  zero, negative (out[WIDTH-1]), carry/borrow, signed overflow
- illegal_op  out  1  result came from an undefined opcode

## Operation
- Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or (codes kept from the previous ALU), 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt (signed a<b → 1 else 0), 1001 mul (low WIDTH bits, unsigned). 1010–1111: illegal.
- Transfer on an edge where valid && ready on the respective side.
- FSM states: IDLE (no result held), BUSY (multiply iterating), DONE (result held).
  - IDLE: in_ready=1. Accepting a non-mul op → DONE. Accepting mul → BUSY.
  - BUSY: in_ready=0. Performs one shift-add iteration per cycle for WIDTH cycles, then → DONE.
  - DONE: out_valid=1; in_ready=out_ready. On out_ready: with in_valid → same as acceptance from IDLE; without in_valid → IDLE.
- Flags:
  - add: c=carry out; v=signed overflow.
  - sub: c=borrow (a<b unsigned); v=signed overflow.
  - sll/srl/sra: c=last bit shifted out, 0 for shift of 0; v=0.
  - mul: c=1 if the upper product half ≠0; v=0.
  - and/or/xor/slt: c=v=0.
  - All ops: z=(out==0); n=out[WIDTH-1].
- Illegal op: out=0, z=1, n=c=v=0, illegal_op=1, 1-cycle latency. illegal_op is 0 for every legal op.
- Result and flags are registered. They stay stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync release): state=IDLE; out=0; all flags=0; illegal_op=0; out_valid=0; in_ready=1 from the first cycle after release.
- Non-mul latency 1: accepted at edge k → out_valid high after edge k.
- mul latency WIDTH: accepted at edge k → out_valid high after edge k+WIDTH. in_ready low for edges k+1..k+WIDTH.
- Throughput: 1 op/cycle for non-mul when out_ready is held high (simultaneous drain + accept in DONE).
- Reset asserted mid-BUSY or in DONE: pending operation and result are discarded; no out_valid is produced for it.
- op, input_a and input_b are sampled only at acceptance. Changes afterwards have no effect on the result in flight.

## Structure
- Package alu_pkg:
  - op code localparams OP_ADD..OP_MUL
  - state enum (IDLE/BUSY/DONE)
  - flag bit positions
- Sub-module alu_mul_iter (WIDTH): shift-add multiplier.
  - Ports: start, a, b → busy, done, product[2*WIDTH-1:0].
  - Same clock/reset_n.
- The combinational single-cycle datapath lives inline in alu_seq.

## Test plan
- Add with WIDTH=16: op=0000, a=0x7FFF, b=0x0001 → out=0x8000, n=1, v=1, c=0, z=0, out_valid one cycle after accept.
- Sub borrow: op=0001, a=0x0003, b=0x0005 → out=0xFFFE, c=1, n=1, v=0.
- Multiply latency and flags:
  - op=1001, a=0x0123, b=0x0010 → out=0x1230, c=0, out_valid exactly 16 cycles after accept, in_ready low throughout.
  - Then a=0x1000, b=0x0010 → out=0x0000, z=1, c=1.
- Backpressure: sra a=0x8001, b=0x0001 → out=0xC000, c=1. Hold out_ready=0 for 5 cycles with in_valid=1 → out/flags stable, in_ready=0. Raise out_ready → next op accepted on the same edge.
- Reset mid-mul: assert reset_n=0 at cycle 7 of a mul → out_valid=0, out=0, in_ready=1 after release. The aborted result never appears.
- Illegal op=1111, a=0xFFFF → out=0, z=1, illegal_op=1. The following legal add clears illegal_op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: bit 0 is folded in at load, the remaining
// WIDTH-1 bits take one cycle each; done marks the final product.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     cnt_q;
    logic               busy_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_q  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_q <= b >> 1;
            cnt_q    <= CNT_INIT;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - 1'b1;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with status flags; single-cycle datapath inline, multiply
// delegated to alu_mul_iter.
//   state | meaning
//   IDLE  | no result held, ready for operands
//   BUSY  | multiply iterating
//   DONE  | result and flags held for the consumer
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal_op
);

    localparam int SHW = $clog2(WIDTH);

    state_t state_q, state_d;

    logic [WIDTH-1:0]   out_q;
    logic [3:0]         flags_q;
    logic               ill_q;
    logic               accept;
    logic               is_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_ill;

    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL);
    assign mul_start = accept && is_mul;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (input_a),
        .b       (input_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = is_mul ? BUSY : DONE;
            BUSY: if (mul_done) state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    if (in_valid) state_d = is_mul ? BUSY : DONE;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == DONE);
        in_ready  = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Shifts run one bit wider so the last bit shifted out lands in wide[WIDTH] or wide[0].
    always_comb begin
        sh      = input_b[SHW-1:0];
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                wide    = {1'b0, input_a} + {1'b0, input_b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != input_a[WIDTH-1]);
            end
            OP_SUB: begin
                wide    = {1'b0, input_a} - {1'b0, input_b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != input_a[WIDTH-1]);
            end
            OP_AND: alu_res = input_a & input_b;
            OP_OR:  alu_res = input_a | input_b;
            OP_XOR: alu_res = input_a ^ input_b;
            OP_SLL: begin
                wide    = {1'b0, input_a} << sh;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_SRL: begin
                wide    = {input_a, 1'b0} >> sh;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            OP_SRA: begin
                wide    = $signed({input_a, 1'b0}) >>> sh;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(input_a) < $signed(input_b))};
            OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= '0;
            flags_q <= '0;
            ill_q   <= 1'b0;
        end else if (accept && !is_mul) begin
            out_q           <= alu_res;
            flags_q[FLAG_Z] <= (alu_res == '0);
            flags_q[FLAG_N] <= alu_res[WIDTH-1];
            flags_q[FLAG_C] <= alu_c;
            flags_q[FLAG_V] <= alu_v;
            ill_q           <= alu_ill;
        end else if (state_q == BUSY && mul_done) begin
            out_q           <= mul_product[WIDTH-1:0];
            flags_q[FLAG_Z] <= (mul_product[WIDTH-1:0] == '0);
            flags_q[FLAG_N] <= mul_product[WIDTH-1];
            flags_q[FLAG_C] <= |mul_product[2*WIDTH-1:WIDTH];
            flags_q[FLAG_V] <= 1'b0;
            ill_q           <= 1'b0;
        end
    end

    assign out        = out_q;
    assign flag_z     = flags_q[FLAG_Z];
    assign flag_n     = flags_q[FLAG_N];
    assign flag_c     = flags_q[FLAG_C];
    assign flag_v     = flags_q[FLAG_V];
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16) with hand-computed expectations.
module tb_alu_seq;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] input_a;
    logic [15:0] input_b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic        illegal_op;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input_a    (input_a),
        .input_b    (input_b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .illegal_op (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // zncv packed as {z,n,c,v}
    function automatic logic [3:0] flags();
        return {flag_z, flag_n, flag_c, flag_v};
    endfunction

    // Accept one single-cycle op with out_ready high, check, then drain.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] e_out,
                         input logic [3:0] e_flags, input logic e_ill);
        op = o; input_a = a; input_b = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_out"}, {16'd0, out}, {16'd0, e_out});
        chk({tag, "_flags"}, {28'd0, flags()}, {28'd0, e_flags});
        chk({tag, "_ill"}, {31'd0, illegal_op}, {31'd0, e_ill});
        tick();
        chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    // Multiply: in_ready/out_valid low for 16 samples, result on the 16th edge.
    task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e_out, input logic [3:0] e_flags);
        int bad;
        bad = 0;
        op = 4'b1001; input_a = a; input_b = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        input_a = 16'hDEAD; input_b = 16'hBEEF; op = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            tick();
        end
        chk({tag, "_busy_window"}, bad, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_out"}, {16'd0, out}, {16'd0, e_out});
        chk({tag, "_flags"}, {28'd0, flags()}, {28'd0, e_flags});
        tick();
        chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int bad;
        int seen;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        input_a = '0; input_b = '0; op = '0;
        #22;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_flags", {28'd0, flags()}, 32'd0);
        chk("rst_ill", {31'd0, illegal_op}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        do_op("add_ovf", 4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0);
        do_op("sub_borrow", 4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1'b0);
        do_op("slt_neg", 4'b1000, 16'hFFFF, 16'h0001, 16'h0001, 4'b0000, 1'b0);
        do_op("sll_carry", 4'b0101, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0);
        do_op("srl_zero", 4'b0110, 16'h8001, 16'h0000, 16'h8001, 4'b0100, 1'b0);
        do_op("and", 4'b0010, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, 1'b0);

        do_mul("mul1", 16'h0123, 16'h0010, 16'h1230, 4'b0000);
        do_mul("mul2", 16'h1000, 16'h0010, 16'h0000, 4'b1010);

        // Backpressure with a pending op held on the input side
        out_ready = 1'b0;
        op = 4'b0111; input_a = 16'h8001; input_b = 16'h0001; in_valid = 1'b1;
        tick();
        op = 4'b0000; input_a = 16'h0001; input_b = 16'h0001;
        chk("sra_out", {16'd0, out}, 32'h0000C000);
        chk("sra_flags", {28'd0, flags()}, 32'h6);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out !== 16'hC000 || flags() !== 4'b0110 || in_ready !== 1'b0 ||
                out_valid !== 1'b1) bad++;
        end
        chk("bp_stable", bad, 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_accept_out", {16'd0, out}, 32'h2);
        chk("bp_accept_valid", {31'd0, out_valid}, 32'd1);
        op = 4'b0100; input_a = 16'hFFFF; input_b = 16'hFFFF;
        tick();
        chk("thru_xor_out", {16'd0, out}, 32'd0);
        chk("thru_xor_flags", {28'd0, flags()}, 32'h8);
        chk("thru_xor_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();

        // Reset during cycle 7 of a multiply
        op = 4'b1001; input_a = 16'h0003; input_b = 16'h0003; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out", {16'd0, out}, 32'd0);
        #3;
        reset_n = 1'b1;
        tick();
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        chk("abort_no_result", seen, 32'd0);

        do_op("illegal", 4'b1111, 16'hFFFF, 16'h0000, 16'h0000, 4'b1000, 1'b1);
        do_op("add_after_ill", 4'b0000, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
